// File: rtl/crt_timing_controller.sv
// Raster scan sequencer: turns PixelClock rising edges into pixel ticks in the Clock
// domain and drives the horizontal/vertical counters plus sync, blanking and strobes.
module crt_timing_controller #(
  parameter int unsigned CounterSize  = 10,
  parameter int unsigned HDisplay     = 640,
  parameter int unsigned HFront       = 16,
  parameter int unsigned HSyncWidth   = 96,
  parameter int unsigned HBack        = 48,
  parameter int unsigned VDisplay     = 480,
  parameter int unsigned VFront       = 10,
  parameter int unsigned VSyncWidth   = 2,
  parameter int unsigned VBack        = 33,
  parameter int unsigned SyncPolarity = 0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   PixelClock,
  output logic                   HSync,
  output logic                   VSync,
  output logic                   VideoOn,
  output logic [CounterSize-1:0] ScanX,
  output logic [CounterSize-1:0] ScanY,
  output logic                   LineStart,
  output logic                   FrameStart
);

  localparam int unsigned HTotal = HDisplay + HFront + HSyncWidth + HBack;
  localparam int unsigned VTotal = VDisplay + VFront + VSyncWidth + VBack;

  localparam logic [CounterSize-1:0] HLast      = CounterSize'(HTotal - 1);
  localparam logic [CounterSize-1:0] VLast      = CounterSize'(VTotal - 1);
  localparam logic [CounterSize-1:0] HVisible   = CounterSize'(HDisplay);
  localparam logic [CounterSize-1:0] VVisible   = CounterSize'(VDisplay);
  localparam logic [CounterSize-1:0] HSyncStart = CounterSize'(HDisplay + HFront);
  localparam logic [CounterSize-1:0] HSyncEnd   = CounterSize'(HDisplay + HFront + HSyncWidth);
  localparam logic [CounterSize-1:0] VSyncStart = CounterSize'(VDisplay + VFront);
  localparam logic [CounterSize-1:0] VSyncEnd   = CounterSize'(VDisplay + VFront + VSyncWidth);
  localparam logic [CounterSize-1:0] CountOne   = CounterSize'(1);
  localparam logic                   SyncActive = 1'(SyncPolarity);

  logic                   PixelPrev;
  logic                   tick;
  logic [CounterSize-1:0] nextX;
  logic [CounterSize-1:0] nextY;
  logic                   hSyncOn;
  logic                   vSyncOn;
  logic                   videoNext;
  logic                   lineNext;
  logic                   frameNext;

  // Next counter values and their decode, so outputs register alongside the counters
  always_comb begin
    tick      = PixelClock & ~PixelPrev;
    nextX     = ScanX;
    nextY     = ScanY;
    if (tick) begin
      if (ScanX == HLast) begin
        nextX = '0;
        nextY = (ScanY == VLast) ? '0 : ScanY + CountOne;
      end else begin
        nextX = ScanX + CountOne;
      end
    end
    hSyncOn   = (nextX >= HSyncStart) && (nextX < HSyncEnd);
    vSyncOn   = (nextY >= VSyncStart) && (nextY < VSyncEnd);
    videoNext = (nextX < HVisible) && (nextY < VVisible);
    lineNext  = tick && (nextX == '0);
    frameNext = lineNext && (nextY == '0);
  end

  // Reset parks the counters on the last position so the first tick lands on (0,0)
  always_ff @(posedge Clock) begin
    PixelPrev <= PixelClock;
    if (Reset) begin
      ScanX      <= HLast;
      ScanY      <= VLast;
      HSync      <= ~SyncActive;
      VSync      <= ~SyncActive;
      VideoOn    <= 1'b0;
      LineStart  <= 1'b0;
      FrameStart <= 1'b0;
    end else begin
      ScanX      <= nextX;
      ScanY      <= nextY;
      HSync      <= hSyncOn ? SyncActive : ~SyncActive;
      VSync      <= vSyncOn ? SyncActive : ~SyncActive;
      VideoOn    <= videoNext;
      LineStart  <= lineNext;
      FrameStart <= frameNext;
    end
  end

endmodule

// File: tb/tb_crt_timing_controller.sv
// Bench for crt_timing_controller: a reference model feeds a scoreboard queue every
// cycle for three instances (VGA active-low, VGA active-high, tiny raster).
module tb_crt_timing_controller;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vo;
    logic [9:0] x;
    logic [9:0] y;
    logic       ls;
    logic       fs;
  } outs_t;

  typedef struct packed {
    outs_t e0;
    outs_t eP;
    outs_t eS;
  } rec_t;

  logic Clock;
  logic Reset;
  logic PixelClock;

  logic       hs0, vs0, vo0, ls0, fs0;
  logic [9:0] x0, y0;
  logic       hsP, vsP, voP, lsP, fsP;
  logic [9:0] xP, yP;
  logic       hsS, vsS, voS, lsS, fsS;
  logic [9:0] xS, yS;

  crt_timing_controller dut0 (
    .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
    .HSync(hs0), .VSync(vs0), .VideoOn(vo0), .ScanX(x0), .ScanY(y0),
    .LineStart(ls0), .FrameStart(fs0)
  );

  crt_timing_controller #(.SyncPolarity(1)) dutP (
    .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
    .HSync(hsP), .VSync(vsP), .VideoOn(voP), .ScanX(xP), .ScanY(yP),
    .LineStart(lsP), .FrameStart(fsP)
  );

  crt_timing_controller #(
    .HDisplay(8), .HFront(2), .HSyncWidth(3), .HBack(2),
    .VDisplay(6), .VFront(2), .VSyncWidth(2), .VBack(1)
  ) dutS (
    .Clock(Clock), .Reset(Reset), .PixelClock(PixelClock),
    .HSync(hsS), .VSync(vsS), .VideoOn(voS), .ScanX(xS), .ScanY(yS),
    .LineStart(lsS), .FrameStart(fsS)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  int    asserts  = 0;
  int    failures = 0;
  outs_t m0, mP, mS;
  logic  mPrev     = 1'b0;
  logic  lastTick  = 1'b0;
  int    tickCount = 0;
  int    pcPhase   = 0;
  int    divMode   = 4;
  rec_t  sb[$];

  // Reference model of one clock edge for a given raster geometry
  function automatic outs_t modelNext(input outs_t cur, input logic tick, input logic rst,
                                      input int hd, input int hf, input int hw, input int hb,
                                      input int vd, input int vf, input int vw, input int vb,
                                      input logic pol);
    outs_t n;
    int    x;
    int    y;
    int    ht;
    int    vt;
    ht = hd + hf + hw + hb;
    vt = vd + vf + vw + vb;
    n  = cur;
    if (rst) begin
      n.x  = 10'(ht - 1);
      n.y  = 10'(vt - 1);
      n.hs = ~pol;
      n.vs = ~pol;
      n.vo = 1'b0;
      n.ls = 1'b0;
      n.fs = 1'b0;
      return n;
    end
    x    = int'(cur.x);
    y    = int'(cur.y);
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (tick) begin
      if (x == ht - 1) begin
        x    = 0;
        y    = (y == vt - 1) ? 0 : y + 1;
        n.ls = 1'b1;
        n.fs = (y == 0);
      end else begin
        x = x + 1;
      end
    end
    n.x  = 10'(x);
    n.y  = 10'(y);
    n.hs = (x >= hd + hf && x < hd + hf + hw) ? pol : ~pol;
    n.vs = (y >= vd + vf && y < vd + vf + vw) ? pol : ~pol;
    n.vo = (x < hd) && (y < vd);
    return n;
  endfunction

  task automatic checkOuts(input string tag, input outs_t obs, input outs_t exp);
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    asserts++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one Clock cycle, queue the model's prediction, compare after the edge
  task automatic step(input logic pc, input logic rst);
    logic tick;
    rec_t rec;
    PixelClock = pc;
    Reset      = rst;
    tick       = pc & ~mPrev;
    m0 = modelNext(m0, tick, rst, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
    mP = modelNext(mP, tick, rst, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1);
    mS = modelNext(mS, tick, rst, 8, 2, 3, 2, 6, 2, 2, 1, 1'b0);
    mPrev    = pc;
    lastTick = tick && !rst;
    if (lastTick) tickCount++;
    sb.push_back('{m0, mP, mS});
    @(posedge Clock);
    #1;
    rec = sb.pop_front();
    checkOuts("dut0", {hs0, vs0, vo0, x0, y0, ls0, fs0}, rec.e0);
    checkOuts("dutP", {hsP, vsP, voP, xP, yP, lsP, fsP}, rec.eP);
    checkOuts("dutS", {hsS, vsS, voS, xS, yS, lsS, fsS}, rec.eS);
  endtask

  task automatic tickStep();
    logic pc;
    pc = (divMode == 4) ? ((pcPhase % 4) < 2) : ((pcPhase % 2) == 0);
    pcPhase++;
    step(pc, 1'b0);
  endtask

  initial begin
    int          found;
    int          startX;
    int          holdX;
    int          strobes;
    int          prevY;
    int          vo639;
    int          vo640;
    int          hsCount;
    int          hsMin;
    int          hsMax;
    int          t0;
    int          vsLow;
    int          vsBad;
    int          voBad;
    logic [799:0] hsSeen;

    Reset      = 1'b1;
    PixelClock = 1'b0;
    @(negedge Clock);

    // Reset held 5 cycles with a /4 PixelClock running
    for (int i = 0; i < 5; i++) begin
      step(((pcPhase % 4) < 2), 1'b1);
      pcPhase++;
    end
    check("rstX", int'(x0), 799);
    check("rstY", int'(y0), 524);
    check("rstHSync", int'(hs0), 1);
    check("rstVSync", int'(vs0), 1);
    check("rstVideoOn", int'(vo0), 0);
    check("rstHSyncPol1", int'(hsP), 0);
    check("rstVSyncPol1", int'(vsP), 0);

    // First tick after release lands on (0,0) with both strobes
    found = 0;
    for (int i = 0; i < 8 && found == 0; i++) begin
      tickStep();
      if (ls0 === 1'b1) found = 1;
    end
    check("firstTickSeen", found, 1);
    check("firstX", int'(x0), 0);
    check("firstY", int'(y0), 0);
    check("firstFrameStart", int'(fs0), 1);
    check("firstVideoOn", int'(vo0), 1);
    tickStep();
    check("strobeWidthLS", int'(ls0), 0);
    check("strobeWidthFS", int'(fs0), 0);

    // /4 PixelClock advances exactly once per 4 Clocks
    startX = int'(x0);
    repeat (40) tickStep();
    check("div4Rate", int'(x0), startX + 10);

    // PixelClock stuck high freezes everything
    step(1'b1, 1'b0);
    holdX   = int'(x0);
    strobes = 0;
    repeat (19) begin
      step(1'b1, 1'b0);
      strobes += int'(ls0 | fs0);
    end
    check("holdX", int'(x0), holdX);
    check("holdStrobes", strobes, 0);

    // Align to the start of a line, then walk one full line
    pcPhase = 2;
    found   = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      tickStep();
      if (ls0 === 1'b1) found = 1;
    end
    check("lineAlign", found, 1);
    hsSeen = '0;
    vo639  = -1;
    vo640  = -1;
    prevY  = -1;
    found  = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      tickStep();
      if (ls0 === 1'b1) begin
        found = 1;
      end else begin
        if (hs0 === 1'b0) hsSeen[x0] = 1'b1;
        if (x0 == 10'd639) vo639 = int'(vo0);
        if (x0 == 10'd640) vo640 = int'(vo0);
        if (x0 == 10'd799) prevY = int'(y0);
      end
    end
    check("lineEnd", found, 1);
    check("lineWrapX", int'(x0), 0);
    check("lineWrapY", int'(y0), prevY + 1);
    check("lineNoFrameStart", int'(fs0), 0);
    check("videoOnAt639", vo639, 1);
    check("videoOnAt640", vo640, 0);
    hsCount = 0;
    hsMin   = 9999;
    hsMax   = -1;
    for (int i = 0; i < 800; i++) begin
      if (hsSeen[i]) begin
        hsCount++;
        if (i < hsMin) hsMin = i;
        if (i > hsMax) hsMax = i;
      end
    end
    check("hsyncTicks", hsCount, 96);
    check("hsyncFirst", hsMin, 656);
    check("hsyncLast", hsMax, 751);

    // /2 PixelClock; reset mid-line at ScanX=300 while PixelClock is high
    divMode = 2;
    pcPhase = 1;
    found   = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      tickStep();
      if (x0 == 10'd300) found = 1;
    end
    check("reachX300", found, 1);
    step(1'b1, 1'b1);
    check("midRstX", int'(x0), 799);
    check("midRstY", int'(y0), 524);
    check("midRstHSync", int'(hs0), 1);
    check("midRstVideoOn", int'(vo0), 0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      check("noTickWhileHigh", int'(x0), 799);
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("postRstX", int'(x0), 0);
    check("postRstLS", int'(ls0), 1);
    check("postRstFS", int'(fs0), 1);
    check("smallFrameStart", int'(fsS), 1);

    // Tiny raster: one full frame at /2
    pcPhase = 1;
    t0      = tickCount;
    vsLow   = 0;
    vsBad   = 0;
    voBad   = 0;
    found   = 0;
    for (int i = 0; i < 1000 && found == 0; i++) begin
      tickStep();
      if (lastTick && vsS === 1'b0) vsLow++;
      if (vsS === 1'b0 && (yS < 10'd8 || yS > 10'd9)) vsBad++;
      if (voS === 1'b1 && yS >= 10'd6) voBad++;
      if (fsS === 1'b1) found = 1;
    end
    check("frameRecur", found, 1);
    check("frameTicks", tickCount - t0, 165);
    check("vsyncTicks", vsLow, 30);
    check("vsyncWindow", vsBad, 0);
    check("blankBelow", voBad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
